// File: rtl/parity_pkg.sv
// Shared constants for the streaming parity unit: frame FSM encoding and parity-mode selection.
package parity_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Turn a raw XOR reduction into an even/odd parity bit.
    function automatic logic apply_mode(input logic raw, input logic mode);
        logic r;
        r = raw;
        case (mode)
            PAR_EVEN: r = raw;
            PAR_ODD:  r = ~raw;
            default:  r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of a WIDTH-bit word (raw even parity).
module parity_reduce #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             par_o
);

    assign par_o = ^data_i;

endmodule

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker: one-deep registered pipeline with valid/ready,
// per-frame accumulated parity and a saturating mismatch counter.
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             odd_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_err,
    output logic             frm_valid,
    output logic             frm_par,
    output logic             frm_active,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_par_q,   out_par_d;
    logic             out_err_q,   out_err_d;
    logic             frm_valid_q, frm_valid_d;
    logic             frm_par_q,   frm_par_d;
    logic             acc_q,       acc_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    logic word_xor;
    logic word_par;
    logic word_mis;
    logic accept;

    parity_reduce #(.WIDTH(WIDTH)) u_reduce (
        .data_i (in_data),
        .par_o  (word_xor)
    );

    assign word_par = apply_mode(word_xor, odd_sel);
    assign word_mis = word_par ^ in_par;

    // Full-throughput skid-free handshake; never ready while held in reset.
    assign in_ready = reset_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_err_d   = out_err_q;
        frm_valid_d = 1'b0;
        frm_par_d   = frm_par_q;
        acc_d       = acc_q;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = word_par;
            out_err_d   = word_mis;

            if (in_last) begin
                frm_par_d   = apply_mode(acc_q ^ word_xor, odd_sel);
                frm_valid_d = 1'b1;
                acc_d       = 1'b0;
                state_d     = ST_IDLE;
            end else begin
                acc_d   = acc_q ^ word_xor;
                state_d = ST_IN_FRAME;
            end

            if (word_mis && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        // Clear wins over a same-cycle increment.
        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frm_valid_q <= 1'b0;
            frm_par_q   <= 1'b0;
            acc_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_err_q   <= out_err_d;
            frm_valid_q <= frm_valid_d;
            frm_par_q   <= frm_par_d;
            acc_q       <= acc_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_par    = out_par_q;
    assign out_err    = out_err_q;
    assign frm_valid  = frm_valid_q;
    assign frm_par    = frm_par_q;
    assign frm_active = (state_q == ST_IN_FRAME);
    assign err_cnt    = err_cnt_q;

endmodule
